// File: rtl/pipe_pkg.sv
// Shared definitions for the front-end pipeline controller: opcodes, FSM states
// and the per-opcode register-read decode.
package pipe_pkg;

  localparam logic [3:0] OP_LW  = 4'h8;
  localparam logic [3:0] OP_SW  = 4'h9;
  localparam logic [3:0] OP_BR  = 4'hD;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StDrain  = 2'd1,
    StHalted = 2'd2
  } ctrl_state_t;

  // FieldSrc1 = instr[7:4], FieldSrc2 = instr[3:0], FieldSw = instr[11:8]
  typedef enum logic [1:0] {
    FieldSrc1,
    FieldSrc2,
    FieldSw
  } field_sel_t;

  function automatic logic uses_src(input logic [3:0] opcode, input field_sel_t field_sel);
    case (field_sel)
      FieldSrc1: return (opcode <= OP_LW) || (opcode == OP_SW) || (opcode == OP_BR);
      FieldSrc2: return (opcode <= 4'h3) || (opcode == 4'h7);
      FieldSw:   return opcode == OP_SW;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low reset; sticks at all-ones.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/fd_pipeline_ctrl.sv
// Fetch/decode hazard, flush and halt sequencer. Pipeline controls are combinational
// from the current state; state, drain count and halted are registered.
module fd_pipeline_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      fd_instr,
  input  logic             dx_is_load,
  input  logic [3:0]       dx_rd,
  input  logic             branch_taken,
  input  logic             mem_stall,
  output logic             pc_wen,
  output logic             fd_wen,
  output logic             fd_flush,
  output logic             dx_wen,
  output logic             dx_flush,
  output logic             halted,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int unsigned DrainW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  ctrl_state_t       state_q, state_d;
  logic [DrainW-1:0] drain_q, drain_d;
  logic              halted_q, halted_d;
  logic              load_use, is_hlt, stall_inc, flush_inc;
  logic [3:0]        opcode;

  always_comb begin
    opcode   = fd_instr[15:12];
    is_hlt   = (opcode == OP_HLT);
    // r0 is hard-wired, so a load targeting it can never feed a consumer.
    load_use = dx_is_load && (dx_rd != 4'd0) &&
               ((uses_src(opcode, FieldSrc1) && (fd_instr[7:4] == dx_rd)) ||
                (uses_src(opcode, FieldSrc2) && (fd_instr[3:0] == dx_rd)) ||
                (uses_src(opcode, FieldSw)   && (fd_instr[11:8] == dx_rd)));
  end

  always_comb begin
    pc_wen    = 1'b0;
    fd_wen    = 1'b0;
    fd_flush  = 1'b0;
    dx_wen    = 1'b0;
    dx_flush  = 1'b0;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    state_d   = state_q;
    drain_d   = drain_q;
    case (state_q)
      StRun: begin
        if (mem_stall) begin
          stall_inc = 1'b1;
        end else if (load_use) begin
          dx_wen    = 1'b1;
          dx_flush  = 1'b1;
          stall_inc = 1'b1;
        end else if (is_hlt) begin
          fd_wen   = 1'b1;
          fd_flush = 1'b1;
          dx_wen   = 1'b1;
          state_d  = StDrain;
          drain_d  = DrainW'(DRAIN_CYCLES - 1);
        end else begin
          pc_wen    = 1'b1;
          fd_wen    = 1'b1;
          dx_wen    = 1'b1;
          fd_flush  = branch_taken;
          flush_inc = branch_taken;
        end
      end
      StDrain: begin
        fd_flush = 1'b1;
        dx_flush = 1'b1;
        if (mem_stall) begin
          stall_inc = 1'b1;
        end else begin
          dx_wen = 1'b1;
          if (drain_q == '0) state_d = StHalted;
          else               drain_d = drain_q - DrainW'(1);
        end
      end
      StHalted: ;
      default: state_d = StRun;
    endcase
    halted_d = (state_d == StHalted);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StRun;
      drain_q  <= '0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      drain_q  <= drain_d;
      halted_q <= halted_d;
    end
  end

  assign halted = halted_q;
  assign state  = state_q;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (stall_inc),
    .cnt (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk (clk),
    .rst (rst),
    .inc (flush_inc),
    .cnt (flush_cnt)
  );

endmodule

// File: tb/tb_fd_pipeline_ctrl.sv
// Bench for fd_pipeline_ctrl: constant vector table, directed corner sequences and
// randomized traffic against a behavioural model. A CNT_W=2 copy shares all inputs.
module tb_fd_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] fd_instr;
  logic        dx_is_load, branch_taken, mem_stall;
  logic [3:0]  dx_rd;
  logic        pc_wen, fd_wen, fd_flush, dx_wen, dx_flush, halted;
  logic [1:0]  state;
  logic [15:0] stall_cnt, flush_cnt;
  logic        s_pc_wen, s_fd_wen, s_fd_flush, s_dx_wen, s_dx_flush, s_halted;
  logic [1:0]  s_state;
  logic [1:0]  s_stall_cnt, s_flush_cnt;

  always #5 clk = ~clk;

  fd_pipeline_ctrl #(.DRAIN_CYCLES(3), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .fd_instr(fd_instr), .dx_is_load(dx_is_load), .dx_rd(dx_rd),
    .branch_taken(branch_taken), .mem_stall(mem_stall), .pc_wen(pc_wen), .fd_wen(fd_wen),
    .fd_flush(fd_flush), .dx_wen(dx_wen), .dx_flush(dx_flush), .halted(halted),
    .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  fd_pipeline_ctrl #(.DRAIN_CYCLES(3), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .fd_instr(fd_instr), .dx_is_load(dx_is_load), .dx_rd(dx_rd),
    .branch_taken(branch_taken), .mem_stall(mem_stall), .pc_wen(s_pc_wen),
    .fd_wen(s_fd_wen), .fd_flush(s_fd_flush), .dx_wen(s_dx_wen), .dx_flush(s_dx_flush),
    .halted(s_halted), .state(s_state), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  int nvec = 0;
  int nerr = 0;

  // Behavioural model: mode 0=run 1=drain 2=halted; remaining = unstalled drain cycles left.
  int          m_mode, m_remaining;
  int unsigned m_stalls, m_flushes;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned sat(input int unsigned v, input int w);
    int unsigned lim = (32'd1 << w) - 1;
    return (v > lim) ? lim : v;
  endfunction

  function automatic bit hazard(input logic [15:0] ins, input logic ld, input logic [3:0] rd);
    int op = int'(ins[15:12]);
    bit reads_a = (op <= 9) || (op == 13);
    bit reads_b = (op <= 3) || (op == 7);
    bit reads_c = (op == 9);
    if (!ld || rd == 4'd0) return 1'b0;
    return (reads_a && ins[7:4] == rd) || (reads_b && ins[3:0] == rd) ||
           (reads_c && ins[11:8] == rd);
  endfunction

  // Expected {pc_wen, fd_wen, fd_flush, dx_wen, dx_flush}.
  function automatic logic [4:0] exp_ctl(input logic [15:0] ins, input logic ld,
                                         input logic [3:0] rd, input logic br, input logic ms);
    if (m_mode == 2) return 5'b00000;
    if (m_mode == 1) return ms ? 5'b00101 : 5'b00111;
    if (ms) return 5'b00000;
    if (hazard(ins, ld, rd)) return 5'b00011;
    if (ins[15:12] == 4'hF) return 5'b01110;
    if (br) return 5'b11110;
    return 5'b11010;
  endfunction

  task automatic model_edge(input logic r, input logic [15:0] ins, input logic ld,
                            input logic [3:0] rd, input logic br, input logic ms);
    if (!r) begin
      m_mode = 0; m_remaining = 0; m_stalls = 0; m_flushes = 0;
    end else if (m_mode == 0) begin
      if (ms || hazard(ins, ld, rd)) m_stalls++;
      else if (ins[15:12] == 4'hF) begin m_mode = 1; m_remaining = 3; end
      else if (br) m_flushes++;
    end else if (m_mode == 1) begin
      if (ms) m_stalls++;
      else begin
        m_remaining--;
        if (m_remaining == 0) m_mode = 2;
      end
    end
  endtask

  task automatic step(input logic r, input logic [15:0] ins, input logic ld,
                      input logic [3:0] rd, input logic br, input logic ms,
                      output logic [4:0] ctl_seen);
    @(negedge clk);
    rst = r; fd_instr = ins; dx_is_load = ld; dx_rd = rd; branch_taken = br; mem_stall = ms;
    #1;
    ctl_seen = {pc_wen, fd_wen, fd_flush, dx_wen, dx_flush};
    check("ctl", 32'(ctl_seen), 32'(exp_ctl(ins, ld, rd, br, ms)));
    @(posedge clk);
    model_edge(r, ins, ld, rd, br, ms);
    #1;
    check("state", 32'(state), 32'(m_mode));
    check("halted", 32'(halted), 32'(m_mode == 2));
    check("stall_cnt", 32'(stall_cnt), sat(m_stalls, 16));
    check("flush_cnt", 32'(flush_cnt), sat(m_flushes, 16));
    check("sat_stall_cnt", 32'(s_stall_cnt), sat(m_stalls, 2));
    check("sat_flush_cnt", 32'(s_flush_cnt), sat(m_flushes, 2));
  endtask

  typedef struct {
    logic [15:0] ins;
    logic        ld;
    logic [3:0]  rd;
    logic        br;
    logic        ms;
    logic [4:0]  ctl;
    int          stalls;
    int          flushes;
  } vec_t;

  localparam logic [15:0] Nop = 16'hC000;

  initial begin
    vec_t       tbl[14];
    logic [4:0] c;
    logic [3:0] op;

    tbl[0]  = '{16'h0234, 1'b1, 4'd3, 1'b0, 1'b0, 5'b00011, 1, 0};
    tbl[1]  = '{16'h0234, 1'b1, 4'd0, 1'b0, 1'b0, 5'b11010, 0, 0};
    tbl[2]  = '{16'hC034, 1'b1, 4'd3, 1'b0, 1'b0, 5'b11010, 0, 0};
    tbl[3]  = '{16'h0234, 1'b1, 4'd4, 1'b0, 1'b0, 5'b00011, 1, 0};
    tbl[4]  = '{16'h9500, 1'b1, 4'd5, 1'b0, 1'b0, 5'b00011, 1, 0};
    tbl[5]  = '{16'h8500, 1'b1, 4'd5, 1'b0, 1'b0, 5'b11010, 0, 0};
    tbl[6]  = '{16'h5004, 1'b1, 4'd4, 1'b0, 1'b0, 5'b11010, 0, 0};
    tbl[7]  = '{16'hD030, 1'b1, 4'd3, 1'b1, 1'b0, 5'b00011, 1, 0};
    tbl[8]  = '{16'h1000, 1'b0, 4'd0, 1'b1, 1'b0, 5'b11110, 0, 1};
    tbl[9]  = '{16'h1000, 1'b0, 4'd0, 1'b1, 1'b1, 5'b00000, 1, 0};
    tbl[10] = '{16'hF000, 1'b0, 4'd0, 1'b0, 1'b0, 5'b01110, 0, 0};
    tbl[11] = '{16'hF123, 1'b1, 4'd1, 1'b1, 1'b0, 5'b01110, 0, 0};
    tbl[12] = '{16'h7012, 1'b1, 4'd2, 1'b0, 1'b0, 5'b00011, 1, 0};
    tbl[13] = '{16'h0000, 1'b0, 4'd0, 1'b0, 1'b0, 5'b11010, 0, 0};

    rst = 1'b0; fd_instr = Nop; dx_is_load = 1'b0; dx_rd = 4'd0;
    branch_taken = 1'b0; mem_stall = 1'b0;
    repeat (2) @(posedge clk);
    model_edge(1'b0, Nop, 1'b0, 4'd0, 1'b0, 1'b0);

    // Reset held with random inputs, then release
    repeat (2) step(1'b0, 16'($urandom), 1'($urandom), 4'($urandom), 1'($urandom),
                    1'($urandom), c);
    step(1'b1, Nop, 1'b0, 4'd0, 1'b0, 1'b0, c);
    check("reset_release_ctl", 32'(c), 32'(5'b11010));

    foreach (tbl[i]) begin
      step(1'b0, Nop, 1'b0, 4'd0, 1'b0, 1'b0, c);
      step(1'b1, tbl[i].ins, tbl[i].ld, tbl[i].rd, tbl[i].br, tbl[i].ms, c);
      check($sformatf("tbl%0d_ctl", i), 32'(c), 32'(tbl[i].ctl));
      check($sformatf("tbl%0d_stall", i), 32'(stall_cnt), 32'(tbl[i].stalls));
      check($sformatf("tbl%0d_flush", i), 32'(flush_cnt), 32'(tbl[i].flushes));
    end

    // Branch held off by mem_stall, then taken
    step(1'b0, Nop, 1'b0, 4'd0, 1'b0, 1'b0, c);
    step(1'b1, 16'h1000, 1'b0, 4'd0, 1'b1, 1'b1, c);
    check("br_stall_flush", 32'(c[2]), 32'd0);
    check("br_stall_cnt", 32'(flush_cnt), 32'd0);
    step(1'b1, 16'h1000, 1'b0, 4'd0, 1'b1, 1'b0, c);
    check("br_go_flush", 32'(c[2]), 32'd1);
    check("br_go_cnt", 32'(flush_cnt), 32'd1);

    // Halt latency: halted rises on the 4th edge counting the HLT edge
    step(1'b0, Nop, 1'b0, 4'd0, 1'b0, 1'b0, c);
    for (int k = 1; k <= 5; k++) begin
      step(1'b1, (k == 1) ? 16'hF000 : Nop, 1'b0, 4'd0, 1'b1, 1'b0, c);
      check($sformatf("halt_lat_%0d", k), 32'(halted), 32'(k >= 4));
    end

    // Halt with two stalled drain cycles: delayed by two edges
    step(1'b0, Nop, 1'b0, 4'd0, 1'b0, 1'b0, c);
    for (int k = 1; k <= 6; k++) begin
      step(1'b1, (k == 1) ? 16'hF000 : Nop, 1'b0, 4'd0, 1'b0, (k == 2 || k == 3), c);
      check($sformatf("halt_stall_%0d", k), 32'(halted), 32'(k == 6));
    end
    check("halt_stall_cnt", 32'(stall_cnt), 32'd2);

    // Reset in the middle of DRAIN
    step(1'b0, Nop, 1'b0, 4'd0, 1'b0, 1'b0, c);
    step(1'b1, 16'hF000, 1'b0, 4'd0, 1'b0, 1'b0, c);
    step(1'b1, Nop, 1'b0, 4'd0, 1'b0, 1'b0, c);
    step(1'b0, Nop, 1'b0, 4'd0, 1'b0, 1'b0, c);
    check("mid_drain_reset", 32'(state), 32'd0);

    // Saturation on the narrow counter
    for (int k = 0; k < 5; k++) step(1'b1, Nop, 1'b0, 4'd0, 1'b0, 1'b1, c);
    check("sat_stall_3", 32'(s_stall_cnt), 32'd3);
    check("wide_stall_5", 32'(stall_cnt), 32'd5);

    // Random traffic: small register range to provoke hazards, rare HLT and reset
    for (int n = 0; n < 3000; n++) begin
      op = ($urandom_range(0, 99) < 4) ? 4'hF : 4'($urandom_range(0, 14));
      step(($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1,
           {op, 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))},
           1'($urandom), 4'($urandom_range(0, 3)), 1'($urandom),
           ($urandom_range(0, 99) < 20), c);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
